seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed two-digit seven-segment display driver. It sits directly downstream of the bit-count/BCD stage and consumes its per-digit segment patterns (tens, ones). It drives one shared segment bus and two digit enables, with dead-time blanking between digits. New patterns are committed only at frame boundaries, so a digit pair never tears mid-frame.

## Interface
- SCAN_DIV, 1000, cycles each digit is lit per slot (≥1)
- DEAD, 8, blank cycles before each digit slot (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; capture ten_seg/one_seg into shadow registers
- ten_seg  in  7  tens-digit segment pattern, bit 6 = a … bit 0 = g, 1 = lit
- one_seg  in  7  ones-digit segment pattern, same encoding
- seg  out  7  shared segment bus, 1 = lit
- dig_en  out  2  digit enables: bit 1 = tens, bit 0 = ones, one-hot or zero
- frame_tick  out  1  one-cycle pulse when a pending pattern pair is committed

## Operation
- Registers:
  - shadow_t/shadow_o (7b each)
  - active_t/active_o (7b each)
  - pending (1b)
  - slot counter, sized for max(SCAN_DIV, DEAD)
  - state
- FSM states: BLANK_T → SHOW_T → BLANK_O → SHOW_O → BLANK_T (cyclic, free-running).
  - BLANK_x lasts DEAD cycles.
  - SHOW_x lasts SCAN_DIV cycles.
  - Counter restarts at 0 on each transition.
- Output decode, registered so it aligns with the current state:
  - BLANK_*: seg=0, dig_en=2'b00.
  - SHOW_T: seg=active_t, dig_en=2'b10.
  - SHOW_O: seg=active_o, dig_en=2'b01.
- load: shadow_t←ten_seg, shadow_o←one_seg, pending←1. Loads are accepted in every state; a later load before commit overwrites the earlier one (last wins).
- Commit happens on the SHOW_O→BLANK_T transition when pending=1:
  - active_t←shadow_t, active_o←shadow_o, pending←0, frame_tick=1 for the first BLANK_T cycle.
  - No commit and no tick if pending=0.
- Simultaneous load and commit in the same cycle:
  - Commit uses the pre-load shadow contents.
  - The new values land in shadow and pending stays 1, so they commit at the next boundary.
- Reset (any time, asynchronous):
  - seg=0, dig_en=0, frame_tick=0, pending=0.
  - All shadow/active registers = 0.
  - state=BLANK_T, counter=0.
  - An in-flight pending load is discarded.
- dig_en is never 2'b11; seg is 0 whenever dig_en is 0.

## Timing
- Frame length: 2·(DEAD+SCAN_DIV) cycles.
- After rst_n deasserts, cycle 0 is the first BLANK_T cycle.
- SHOW_T begins at cycle DEAD; BLANK_O at DEAD+SCAN_DIV; SHOW_O at 2·DEAD+SCAN_DIV.
- Load-to-display latency depends on the load position:
  - Minimum: the rest of the current frame plus DEAD cycles.
  - Maximum: one full frame plus DEAD cycles after the load cycle.
- frame_tick coincides with the first BLANK_T cycle of the new frame. The committed active_t appears on seg DEAD cycles later.
- Outputs are glitch-free registers; no combinational path from inputs to outputs.

## Configuration
- LZ_BLANK_EN (leading-zero blanking):
  - Defined: during SHOW_T, if active_t == 7'b1111110 (digit 0), seg=0 and dig_en=2'b00 for the whole slot. Slot timing is unchanged.
  - Undefined: the tens digit is always shown as committed.

## Test plan
- Reset/scan, SCAN_DIV=4, DEAD=2, no load:
  - Cycles 0–1 dig_en=00.
  - Cycles 2–5 dig_en=10, seg=0.
  - Cycles 6–7 dig_en=00.
  - Cycles 8–11 dig_en=01, seg=0.
  - Pattern repeats at cycle 12; frame_tick never asserts.
- Load "12" (ten_seg=0110000, one_seg=1101101) at cycle 3:
  - frame_tick=1 at cycle 12 only.
  - seg=0110000 during cycles 14–17; seg=1101101 during cycles 20–23.
- Double load: load "12" at cycle 3, then "34" (1111001, 0110011) at cycle 9 → only "34" is displayed from cycle 14; exactly one frame_tick.
- Load in boundary cycle 11:
  - With an earlier pending "12": "12" commits at cycle 12; the cycle-11 value commits at cycle 24 with a second tick.
  - With nothing pending: no tick at 12; commit and tick at 24.
- Mid-frame reset: assert rst_n=0 at cycle 16 with "12" active → seg/dig_en go to 0 immediately. After release, the scan restarts with blank digits (seg=0) and no frame_tick.
- LZ_BLANK_EN defined, load "05" (1111110, 1011011) → tens slot shows dig_en=00, seg=0; ones slot shows 1011011. Without the macro, the tens slot shows 1111110 with dig_en=10.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with dead-time blanking and frame-boundary commit.
// Optional leading-zero blanking of the tens digit: define LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEAD     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] ten_seg,
  input  logic [6:0] one_seg,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int unsigned MAXC = (SCAN_DIV > DEAD) ? SCAN_DIV : DEAD;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {BLANK_T, SHOW_T, BLANK_O, SHOW_O} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      shadow_t_q, shadow_t_d, shadow_o_q, shadow_o_d;
  logic [6:0]      active_t_q, active_t_d, active_o_q, active_o_d;
  logic            pending_q, pending_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      dig_en_q, dig_en_d;
  logic            tick_q, tick_d;
  logic            last, commit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    last       = 1'b0;
    commit     = 1'b0;
    shadow_t_d = shadow_t_q;
    shadow_o_d = shadow_o_q;
    active_t_d = active_t_q;
    active_o_d = active_o_q;
    pending_d  = pending_q;
    seg_d      = '0;
    dig_en_d   = '0;

    unique case (state_q)
      BLANK_T, BLANK_O: last = (cnt_q == CW'(DEAD - 1));
      default:          last = (cnt_q == CW'(SCAN_DIV - 1));
    endcase

    if (last) begin
      cnt_d = '0;
      unique case (state_q)
        BLANK_T: state_d = SHOW_T;
        SHOW_T:  state_d = BLANK_O;
        BLANK_O: state_d = SHOW_O;
        default: state_d = BLANK_T;
      endcase
    end

    // Commit reads the pre-load shadow; a same-cycle load stays pending for the next frame.
    commit = last && (state_q == SHOW_O) && pending_q;
    if (commit) begin
      active_t_d = shadow_t_q;
      active_o_d = shadow_o_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shadow_t_d = ten_seg;
      shadow_o_d = one_seg;
      pending_d  = 1'b1;
    end
    tick_d = commit;

    // Outputs decoded from next state so the registered values line up with state_q.
    unique case (state_d)
      SHOW_T: begin
        seg_d    = active_t_d;
        dig_en_d = 2'b10;
`ifdef LZ_BLANK_EN
        if (active_t_d == 7'b1111110) begin
          seg_d    = '0;
          dig_en_d = '0;
        end
`endif
      end
      SHOW_O: begin
        seg_d    = active_o_d;
        dig_en_d = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK_T;
      cnt_q      <= '0;
      shadow_t_q <= '0;
      shadow_o_q <= '0;
      active_t_q <= '0;
      active_o_q <= '0;
      pending_q  <= 1'b0;
      seg_q      <= '0;
      dig_en_q   <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_t_q <= shadow_t_d;
      shadow_o_q <= shadow_o_d;
      active_t_q <= active_t_d;
      active_o_q <= active_o_d;
      pending_q  <= pending_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
      tick_q     <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, DEAD=2 (12-cycle frame).
module tb_seg_scan_driver;

  localparam logic [6:0] T1 = 7'b0110000, O2 = 7'b1101101;
  localparam logic [6:0] T3 = 7'b1111001, O4 = 7'b0110011;
  localparam logic [6:0] Z0 = 7'b1111110, O5 = 7'b1011011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] ten_seg = '0, one_seg = '0;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       frame_tick;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  seg_scan_driver #(.SCAN_DIV(4), .DEAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .ten_seg(ten_seg), .one_seg(one_seg),
    .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seg, 7'd0);
    chk("rst_en", {5'd0, dig_en}, 7'd0);
    chk("rst_tick", {6'd0, frame_tick}, 7'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  // One cycle: drive inputs, check outputs against displayed pair (et, eo) and tick.
  task automatic step(input logic ld, input logic [6:0] t, input logic [6:0] o,
                      input logic [6:0] et, input logic [6:0] eo, input logic etick);
    int p;
    logic [6:0] e_seg;
    logic [1:0] e_en;
    load = ld; ten_seg = t; one_seg = o;
    p = cyc % 12;
    e_seg = '0;
    e_en  = 2'b00;
    if (p >= 2 && p < 6) begin
      e_seg = et; e_en = 2'b10;
`ifdef LZ_BLANK_EN
      if (et == Z0) begin e_seg = '0; e_en = 2'b00; end
`endif
    end else if (p >= 8) begin
      e_seg = eo; e_en = 2'b01;
    end
    @(negedge clk);
    chk("seg", seg, e_seg);
    chk("dig_en", {5'd0, dig_en}, {5'd0, e_en});
    chk("frame_tick", {6'd0, frame_tick}, {6'd0, etick});
    @(posedge clk);
    #1 load = 1'b0;
    cyc++;
  endtask

  initial begin
    // Free-running scan, nothing loaded
    do_reset();
    for (int c = 0; c < 24; c++) step(1'b0, '0, '0, '0, '0, 1'b0);

    // Load "12" at cycle 3
    do_reset();
    for (int c = 0; c < 36; c++)
      step(c == 3, T1, O2, (c >= 12) ? T1 : 7'd0, (c >= 12) ? O2 : 7'd0, c == 12);

    // Double load, last one wins
    do_reset();
    for (int c = 0; c < 24; c++)
      step(c == 3 || c == 9, (c == 3) ? T1 : T3, (c == 3) ? O2 : O4,
           (c >= 12) ? T3 : 7'd0, (c >= 12) ? O4 : 7'd0, c == 12);

    // Boundary load at cycle 11 with "12" already pending
    do_reset();
    for (int c = 0; c < 36; c++)
      step(c == 3 || c == 11, (c == 3) ? T1 : T3, (c == 3) ? O2 : O4,
           (c >= 24) ? T3 : (c >= 12) ? T1 : 7'd0,
           (c >= 24) ? O4 : (c >= 12) ? O2 : 7'd0, c == 12 || c == 24);

    // Boundary load at cycle 11 with nothing pending
    do_reset();
    for (int c = 0; c < 36; c++)
      step(c == 11, T3, O4, (c >= 24) ? T3 : 7'd0, (c >= 24) ? O4 : 7'd0, c == 24);

    // Mid-frame reset with "12" active and "34" pending
    do_reset();
    for (int c = 0; c < 16; c++)
      step(c == 3 || c == 15, (c == 3) ? T1 : T3, (c == 3) ? O2 : O4,
           (c >= 12) ? T1 : 7'd0, (c >= 12) ? O2 : 7'd0, c == 12);
    rst_n = 1'b0;
    #1;
    chk("async_seg", seg, 7'd0);
    chk("async_en", {5'd0, dig_en}, 7'd0);
    chk("async_tick", {6'd0, frame_tick}, 7'd0);
    do_reset();
    for (int c = 0; c < 36; c++) step(1'b0, '0, '0, '0, '0, 1'b0);

    // "05": tens digit is zero
    do_reset();
    for (int c = 0; c < 24; c++)
      step(c == 5, Z0, O5, (c >= 12) ? Z0 : 7'd0, (c >= 12) ? O5 : 7'd0, c == 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
